// File: rtl/ans_freq_table_if.sv
// Training-stream and model-read bundle between the rANS decoder side (master) and the frequency table (slave).
interface ans_freq_table_if #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 8
);
    logic [SYM_WIDTH-1:0]           sym_in;
    logic                           sym_vld;
    logic                           sym_last;
    logic                           sym_rdy;
    logic                           tbl_clr;
    logic                           table_ready;
    logic [1:0]                     read_type;
    logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query;
    logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result;
    logic                           read_rdy;

    modport master (
        output sym_in, sym_vld, sym_last, tbl_clr, read_type, read_query,
        input  sym_rdy, table_ready, read_result, read_rdy
    );

    modport slave (
        input  sym_in, sym_vld, sym_last, tbl_clr, read_type, read_query,
        output sym_rdy, table_ready, read_result, read_rdy
    );
endinterface

// File: rtl/ans_freq_table.sv
// Symbol histogram -> sequential cumulative table -> PMF/CMF (1 cycle) and linear-scan ICMF (s+1 cycles) reads.
// Training is never stalled while sym_rdy=1; reads hold read_rdy/read_result until the request changes or drops to NONE.
module ans_freq_table #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 8,
    parameter int SYM_COUNT = 1 << SYM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    ans_freq_table_if.slave  bus
);
    localparam int                   QW       = CNT_WIDTH + SYM_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);
    localparam logic [1:0]           RD_NONE  = 2'd0;
    localparam logic [1:0]           RD_PMF   = 2'd1;
    localparam logic [1:0]           RD_ICMF  = 2'd3;

    typedef enum logic [1:0] {TRAIN, BUILD, SERVE, LOOKUP} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [SYM_COUNT];
    logic [CNT_WIDTH-1:0] cnt_d [SYM_COUNT];
    logic [QW-1:0]        cmf_q [SYM_COUNT];
    logic [QW-1:0]        cmf_d [SYM_COUNT];
    logic [SYM_WIDTH-1:0] idx_q, idx_d;
    logic [SYM_WIDTH-1:0] scan_q, scan_d;
    logic [1:0]           lat_type_q, lat_type_d;
    logic [QW-1:0]        lat_query_q, lat_query_d;
    logic                 pend_q, pend_d;
    logic                 sym_rdy_q, sym_rdy_d;
    logic                 table_ready_q, table_ready_d;
    logic                 read_rdy_q, read_rdy_d;
    logic [QW-1:0]        read_result_q, read_result_d;

    logic                 req_changed;
    logic [SYM_WIDTH-1:0] lat_sym;
    logic [QW-1:0]        cmf_prev;

    assign req_changed = (bus.read_type != lat_type_q) || (bus.read_query != lat_query_q);
    assign lat_sym     = lat_query_q[SYM_WIDTH-1:0];
    assign cmf_prev    = (idx_q == '0) ? '0 : cmf_q[idx_q - SYM_WIDTH'(1)];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmf_d         = cmf_q;
        idx_d         = idx_q;
        scan_d        = scan_q;
        lat_type_d    = lat_type_q;
        lat_query_d   = lat_query_q;
        pend_d        = pend_q;
        sym_rdy_d     = sym_rdy_q;
        table_ready_d = table_ready_q;
        read_rdy_d    = read_rdy_q;
        read_result_d = read_result_q;

        case (state_q)
            TRAIN: begin
                if (bus.sym_vld) begin
                    if (cnt_q[bus.sym_in] != CNT_MAX)
                        cnt_d[bus.sym_in] = cnt_q[bus.sym_in] + CNT_WIDTH'(1);
                    if (bus.sym_last) begin
                        state_d   = BUILD;
                        sym_rdy_d = 1'b0;
                        idx_d     = '0;
                    end
                end
            end

            BUILD: begin
                cmf_d[idx_q] = cmf_prev + {{SYM_WIDTH{1'b0}}, cnt_q[idx_q]};
                idx_d        = idx_q + SYM_WIDTH'(1);
                if (idx_q == LAST_SYM) begin
                    state_d       = SERVE;
                    table_ready_d = 1'b1;
                end
            end

            SERVE: begin
                if (bus.tbl_clr) begin
                    for (int i = 0; i < SYM_COUNT; i++) begin
                        cnt_d[i] = '0;
                        cmf_d[i] = '0;
                    end
                    state_d       = TRAIN;
                    sym_rdy_d     = 1'b1;
                    table_ready_d = 1'b0;
                    read_rdy_d    = 1'b0;
                    read_result_d = '0;
                    pend_d        = 1'b0;
                    lat_type_d    = RD_NONE;
                    lat_query_d   = '0;
                end else if (bus.read_type == RD_NONE) begin
                    read_rdy_d = 1'b0;
                    pend_d     = 1'b0;
                end else if (req_changed || (!read_rdy_q && !pend_q)) begin
                    lat_type_d  = bus.read_type;
                    lat_query_d = bus.read_query;
                    read_rdy_d  = 1'b0;
                    if (bus.read_type == RD_ICMF) begin
                        state_d = LOOKUP;
                        scan_d  = '0;
                        pend_d  = 1'b0;
                    end else begin
                        pend_d  = 1'b1;
                    end
                end else if (pend_q) begin
                    // PMF/CMF answer comes from the latched operand, one edge after sampling
                    pend_d        = 1'b0;
                    read_rdy_d    = 1'b1;
                    read_result_d = (lat_type_q == RD_PMF) ? {{SYM_WIDTH{1'b0}}, cnt_q[lat_sym]}
                                                           : cmf_q[lat_sym];
                end
            end

            LOOKUP: begin
                if (bus.read_type == RD_NONE) begin
                    read_rdy_d = 1'b0;
                    state_d    = SERVE;
                end else if (req_changed) begin
                    lat_type_d  = bus.read_type;
                    lat_query_d = bus.read_query;
                    read_rdy_d  = 1'b0;
                    if (bus.read_type == RD_ICMF) begin
                        scan_d = '0;
                    end else begin
                        state_d = SERVE;
                        pend_d  = 1'b1;
                    end
                end else if ((cmf_q[scan_q] > lat_query_q) || (scan_q == LAST_SYM)) begin
                    read_result_d = {{CNT_WIDTH{1'b0}}, scan_q};
                    read_rdy_d    = 1'b1;
                    state_d       = SERVE;
                end else begin
                    scan_d = scan_q + SYM_WIDTH'(1);
                end
            end

            default: state_d = TRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= TRAIN;
            for (int i = 0; i < SYM_COUNT; i++) begin
                cnt_q[i] <= '0;
                cmf_q[i] <= '0;
            end
            idx_q         <= '0;
            scan_q        <= '0;
            lat_type_q    <= RD_NONE;
            lat_query_q   <= '0;
            pend_q        <= 1'b0;
            sym_rdy_q     <= 1'b1;
            table_ready_q <= 1'b0;
            read_rdy_q    <= 1'b0;
            read_result_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmf_q         <= cmf_d;
            idx_q         <= idx_d;
            scan_q        <= scan_d;
            lat_type_q    <= lat_type_d;
            lat_query_q   <= lat_query_d;
            pend_q        <= pend_d;
            sym_rdy_q     <= sym_rdy_d;
            table_ready_q <= table_ready_d;
            read_rdy_q    <= read_rdy_d;
            read_result_q <= read_result_d;
        end
    end

    assign bus.sym_rdy     = sym_rdy_q;
    assign bus.table_ready = table_ready_q;
    assign bus.read_rdy    = read_rdy_q;
    assign bus.read_result = read_result_q;
endmodule

// File: tb/tb_ans_freq_table.sv
// Directed bench for ans_freq_table: training, build timing, PMF/CMF/ICMF reads, handshake and clear/reset paths.
module tb_ans_freq_table;
    localparam int SW = 4;
    localparam int CW = 8;
    localparam int QW = SW + CW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ans_freq_table_if #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [SW-1:0] s, input logic last);
        bus.sym_in   = s;
        bus.sym_vld  = 1'b1;
        bus.sym_last = last;
        tick();
        bus.sym_vld  = 1'b0;
        bus.sym_last = 1'b0;
    endtask

    // Counts edges after the final training beat until table_ready rises; -1 on timeout.
    task automatic wait_table(output int cyc);
        cyc = 0;
        while (!bus.table_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!bus.table_ready) cyc = -1;
    endtask

    // Drives a request and returns the result and the number of edges until read_rdy (sampling edge included).
    task automatic do_read(input logic [1:0] t, input logic [QW-1:0] q,
                           output logic [QW-1:0] res, output int edges);
        bus.read_type  = t;
        bus.read_query = q;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus.read_rdy && edges < 40);
        if (!bus.read_rdy) edges = -1;
        res = bus.read_result;
    endtask

    task automatic idle();
        bus.read_type = 2'd0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (bus.sym_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_sym_rdy: got %b want 1", bus.sym_rdy); end
        n_cmp++; if (bus.table_ready !== 1'b0) begin n_bad++; $display("FAIL reset_table_ready: got %b want 0", bus.table_ready); end
        n_cmp++; if (bus.read_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_read_rdy: got %b want 0", bus.read_rdy); end
        n_cmp++; if (bus.read_result !== '0) begin n_bad++; $display("FAIL reset_read_result: got %0d want 0", bus.read_result); end
    endtask

    task automatic test_pmf_cmf();
        int            cyc;
        int            e;
        logic [QW-1:0] r;
        send_sym(4'd0, 1'b0);
        send_sym(4'd0, 1'b0);
        send_sym(4'd1, 1'b0);
        send_sym(4'd3, 1'b1);
        n_cmp++; if (bus.sym_rdy !== 1'b0) begin n_bad++; $display("FAIL build_sym_rdy: got %b want 0", bus.sym_rdy); end
        wait_table(cyc);
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL build_cycles: got %0d want 16", cyc); end
        do_read(2'd1, 12'd0, r, e);
        n_cmp++; if (r !== 12'd2) begin n_bad++; $display("FAIL pmf0: got %0d want 2", r); end
        n_cmp++; if (e !== 2) begin n_bad++; $display("FAIL pmf_latency: got L=%0d want L=1", e - 1); end
        idle();
        do_read(2'd1, 12'd2, r, e);
        n_cmp++; if (r !== 12'd0) begin n_bad++; $display("FAIL pmf2: got %0d want 0", r); end
        do_read(2'd2, 12'd1, r, e);
        n_cmp++; if (r !== 12'd3) begin n_bad++; $display("FAIL cmf1: got %0d want 3", r); end
        do_read(2'd2, 12'd15, r, e);
        n_cmp++; if (r !== 12'd4) begin n_bad++; $display("FAIL cmf15: got %0d want 4", r); end
        n_cmp++; if (e !== 2) begin n_bad++; $display("FAIL cmf_latency: got L=%0d want L=1", e - 1); end
        idle();
    endtask

    task automatic test_icmf();
        logic [QW-1:0] qs [4];
        logic [QW-1:0] want [4];
        int            lat [4];
        logic [QW-1:0] r;
        int            e;
        qs   = '{12'd0, 12'd2, 12'd3, 12'd4};
        want = '{12'd0, 12'd1, 12'd3, 12'd15};
        lat  = '{1, 2, 4, 16};
        for (int i = 0; i < 4; i++) begin
            do_read(2'd3, qs[i], r, e);
            n_cmp++; if (r !== want[i]) begin n_bad++; $display("FAIL icmf_q%0d: got %0d want %0d", qs[i], r, want[i]); end
            n_cmp++; if (e !== lat[i] + 1) begin n_bad++; $display("FAIL icmf_lat_q%0d: got L=%0d want L=%0d", qs[i], e - 1, lat[i]); end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [QW-1:0] r;
        int            e;
        do_read(2'd2, 12'd15, r, e);
        n_cmp++; if (r !== 12'd4 || e < 0) begin n_bad++; $display("FAIL b2b_cmf15: got %0d want 4", r); end
        bus.read_type = 2'd0;
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_after_none: got %b want 0", bus.read_rdy); end
        bus.read_type  = 2'd1;
        bus.read_query = 12'd3;
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_stale_rdy: got %b want 0", bus.read_rdy); end
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_pmf_rdy: got %b want 1", bus.read_rdy); end
        n_cmp++; if (bus.read_result !== 12'd1) begin n_bad++; $display("FAIL b2b_pmf3: got %0d want 1", bus.read_result); end
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b1 || bus.read_result !== 12'd1) begin n_bad++; $display("FAIL b2b_hold: got rdy=%b res=%0d want rdy=1 res=1", bus.read_rdy, bus.read_result); end
        idle();
    endtask

    task automatic test_query_change();
        bus.read_type  = 2'd3;
        bus.read_query = 12'd3;
        tick();
        tick();
        bus.read_query = 12'd0;
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b0) begin n_bad++; $display("FAIL qchg_rdy_at_change: got %b want 0", bus.read_rdy); end
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b1) begin n_bad++; $display("FAIL qchg_rdy: got %b want 1", bus.read_rdy); end
        n_cmp++; if (bus.read_result !== 12'd0) begin n_bad++; $display("FAIL qchg_result: got %0d want 0", bus.read_result); end
        idle();
    endtask

    task automatic test_tbl_clr();
        bus.tbl_clr = 1'b1;
        tick();
        bus.tbl_clr = 1'b0;
        n_cmp++; if (bus.table_ready !== 1'b0) begin n_bad++; $display("FAIL clr_table_ready: got %b want 0", bus.table_ready); end
        n_cmp++; if (bus.sym_rdy !== 1'b1) begin n_bad++; $display("FAIL clr_sym_rdy: got %b want 1", bus.sym_rdy); end
    endtask

    task automatic test_saturation();
        int            cyc;
        int            e;
        logic [QW-1:0] r;
        for (int i = 0; i < 300; i++) send_sym(4'd5, (i == 299));
        wait_table(cyc);
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL sat_build_cycles: got %0d want 16", cyc); end
        do_read(2'd1, 12'd5, r, e);
        n_cmp++; if (r !== 12'd255) begin n_bad++; $display("FAIL sat_pmf5: got %0d want 255", r); end
        do_read(2'd2, 12'd15, r, e);
        n_cmp++; if (r !== 12'd255) begin n_bad++; $display("FAIL sat_cmf15: got %0d want 255", r); end
        do_read(2'd2, 12'd4, r, e);
        n_cmp++; if (r !== 12'd0) begin n_bad++; $display("FAIL sat_cmf4_cleared: got %0d want 0", r); end
        idle();
    endtask

    task automatic test_train_read_hold();
        int   cyc;
        logic seen;
        bus.tbl_clr = 1'b1;
        tick();
        bus.tbl_clr    = 1'b0;
        bus.read_type  = 2'd2;
        bus.read_query = 12'd15;
        seen = 1'b0;
        send_sym(4'd1, 1'b0); seen |= bus.read_rdy;
        send_sym(4'd2, 1'b1); seen |= bus.read_rdy;
        cyc = 0;
        while (!bus.table_ready && cyc < 100) begin
            tick();
            cyc++;
            seen |= bus.read_rdy;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL hold_rdy_before_serve: got %b want 0", seen); end
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b0) begin n_bad++; $display("FAIL hold_first_serve_edge: got %b want 0", bus.read_rdy); end
        tick();
        n_cmp++; if (bus.read_rdy !== 1'b1 || bus.read_result !== 12'd2) begin n_bad++; $display("FAIL hold_cmf15: got rdy=%b res=%0d want rdy=1 res=2", bus.read_rdy, bus.read_result); end
        idle();
    endtask

    task automatic test_reset_mid_build();
        int            cyc;
        int            e;
        logic [QW-1:0] r;
        bus.tbl_clr = 1'b1;
        tick();
        bus.tbl_clr = 1'b0;
        send_sym(4'd9, 1'b0);
        send_sym(4'd9, 1'b1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.sym_rdy !== 1'b1 || bus.table_ready !== 1'b0) begin n_bad++; $display("FAIL rst_build_state: got sym_rdy=%b table_ready=%b want 1/0", bus.sym_rdy, bus.table_ready); end
        send_sym(4'd7, 1'b1);
        wait_table(cyc);
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL rst_rebuild_cycles: got %0d want 16", cyc); end
        do_read(2'd1, 12'd9, r, e);
        n_cmp++; if (r !== 12'd0) begin n_bad++; $display("FAIL rst_pmf9: got %0d want 0", r); end
        do_read(2'd1, 12'd7, r, e);
        n_cmp++; if (r !== 12'd1) begin n_bad++; $display("FAIL rst_pmf7: got %0d want 1", r); end
        do_read(2'd2, 12'd6, r, e);
        n_cmp++; if (r !== 12'd0) begin n_bad++; $display("FAIL rst_cmf6: got %0d want 0", r); end
        do_read(2'd3, 12'd0, r, e);
        n_cmp++; if (r !== 12'd7) begin n_bad++; $display("FAIL rst_icmf0: got %0d want 7", r); end
        idle();
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.sym_in     = '0;
        bus.sym_vld    = 1'b0;
        bus.sym_last   = 1'b0;
        bus.tbl_clr    = 1'b0;
        bus.read_type  = 2'd0;
        bus.read_query = '0;
        test_reset();
        test_pmf_cmf();
        test_icmf();
        test_back_to_back();
        test_query_change();
        test_tbl_clr();
        test_saturation();
        test_train_read_hold();
        test_reset_mid_build();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
